div16x8: RTL

- Iterative 16÷8 divider for HD6309 DIVD-class operations.
- It is the inverse counterpart of the pipelined 8x8 multiplier feeding the ALU's MUL path.
- The sequencer launches it with a start pulse and receives quotient, remainder and a 4-bit {N,Z,V,C} flag nibble in the same layout the 16-bit ALU returns.
- It supports signed and unsigned modes and is multi-cycle, with busy/done handshake.

---
 rtl/div16x8_pkg.sv | 40 ++++
 rtl/div16x8_div_step.sv | 23 ++
 rtl/div16x8.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/div16x8_pkg.sv
// Shared definitions for the 16/8 iterative divider: FSM encoding, CCR flag
// positions and latency. Optional macro DIV_RADIX4_EN selects two quotient
// bits per CALC cycle.
package div16x8_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StFix  = 2'd2,
    StDone = 2'd3
  } div_state_e;

  // Flag positions inside CCRo, same layout as the 16-bit ALU CCR nibble.
  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_V = 1;
  localparam int unsigned FLAG_C = 0;

  localparam int unsigned DIV_STEPS = 16;

`ifdef DIV_RADIX4_EN
  localparam int unsigned DIV_BITS_PER_CYCLE = 2;
  localparam int unsigned DIV_LATENCY        = 9;
`else
  localparam int unsigned DIV_BITS_PER_CYCLE = 1;
  localparam int unsigned DIV_LATENCY        = 17;
`endif

  function automatic logic [3:0] pack_ccr(input logic n, input logic z,
                                          input logic v, input logic c);
    logic [3:0] f;
    f         = 4'b0000;
    f[FLAG_N] = n;
    f[FLAG_Z] = z;
    f[FLAG_V] = v;
    f[FLAG_C] = c;
    return f;
  endfunction

endpackage

// File: rtl/div16x8_div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial
// subtract the divisor magnitude, keep the difference when it does not borrow.
module div_step (
  input  logic [8:0] prem_in,
  input  logic       bit_in,
  input  logic [8:0] dsr_in,
  output logic [8:0] prem_out,
  output logic       q_out
);

  logic [9:0] w_shift;
  logic [9:0] w_diff;

  // Partial remainder stays below the divisor (<= 256), so the shifted value
  // fits in 10 bits and bit 9 of the difference is a clean borrow.
  always_comb begin
    w_shift  = {prem_in, bit_in};
    w_diff   = w_shift - {1'b0, dsr_in};
    q_out    = ~w_diff[9];
    prem_out = q_out ? w_diff[8:0] : w_shift[8:0];
  end

endmodule

// File: rtl/div16x8.sv
// Iterative 16/8 divider (signed/unsigned) with busy/done handshake and
// {N,Z,V,C} flags. Optional macro DIV_RADIX4_EN: two restoring steps per clock.
module div16x8
  import div16x8_pkg::*;
#(
  parameter int unsigned STEPS = DIV_STEPS
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        start_in,
  input  logic        signed_in,
  input  logic [15:0] dividend_in,
  input  logic [7:0]  divisor_in,
  output logic        busy_out,
  output logic        done_out,
  output logic [7:0]  quot_out,
  output logic [7:0]  rem_out,
  output logic        div0_out,
  output logic [3:0]  CCRo
);

  localparam logic [3:0] CntLoad = 4'(STEPS / DIV_BITS_PER_CYCLE - 1);

  div_state_e  r_state;
  logic [3:0]  r_cnt;
  logic [15:0] r_dvd;
  logic [8:0]  r_dsr;
  logic [8:0]  r_prem;
  logic [15:0] r_quo;
  logic        r_qneg;
  logic        r_rneg;
  logic        r_sgn;
  logic        r_busy;
  logic        r_done;
  logic [7:0]  r_quot;
  logic [7:0]  r_rem;
  logic        r_div0;
  logic [3:0]  r_ccr;

  logic        w_dvd_neg;
  logic        w_dsr_neg;
  logic [15:0] w_dvd_mag;
  logic [8:0]  w_dsr_mag;
  logic [8:0]  w_prem0;
  logic        w_q0;
  logic [8:0]  w_prem_nxt;
  logic [15:0] w_quo_nxt;
  logic [15:0] w_dvd_nxt;
  logic [7:0]  w_quot_s;
  logic [7:0]  w_rem_s;
  logic        w_ovf;

  // Operand magnitudes at the start edge; divisor is 9 bits so -128 maps to 128.
  always_comb begin
    w_dvd_neg = signed_in & dividend_in[15];
    w_dsr_neg = signed_in & divisor_in[7];
    w_dvd_mag = w_dvd_neg ? (16'd0 - dividend_in) : dividend_in;
    w_dsr_mag = w_dsr_neg ? (9'd0 - {divisor_in[7], divisor_in}) : {1'b0, divisor_in};
  end

  div_step u_step0 (
    .prem_in  (r_prem),
    .bit_in   (r_dvd[15]),
    .dsr_in   (r_dsr),
    .prem_out (w_prem0),
    .q_out    (w_q0)
  );

`ifdef DIV_RADIX4_EN
  logic [8:0] w_prem1;
  logic       w_q1;

  div_step u_step1 (
    .prem_in  (w_prem0),
    .bit_in   (r_dvd[14]),
    .dsr_in   (r_dsr),
    .prem_out (w_prem1),
    .q_out    (w_q1)
  );

  // Two quotient bits per cycle.
  always_comb begin
    w_prem_nxt = w_prem1;
    w_quo_nxt  = {r_quo[13:0], w_q0, w_q1};
    w_dvd_nxt  = {r_dvd[13:0], 2'b00};
  end
`else
  // One quotient bit per cycle.
  always_comb begin
    w_prem_nxt = w_prem0;
    w_quo_nxt  = {r_quo[14:0], w_q0};
    w_dvd_nxt  = {r_dvd[14:0], 1'b0};
  end
`endif

  // Sign fix-up and overflow detection on the final magnitudes.
  always_comb begin
    w_quot_s = r_qneg ? (8'd0 - r_quo[7:0]) : r_quo[7:0];
    w_rem_s  = r_rneg ? (8'd0 - r_prem[7:0]) : r_prem[7:0];
    if (r_sgn) begin
      w_ovf = r_qneg ? (r_quo > 16'd128) : (r_quo > 16'd127);
    end else begin
      w_ovf = (r_quo > 16'd255);
    end
  end

  // Sequencer FSM with registered handshake and result outputs.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state <= StIdle;
      r_cnt   <= 4'd0;
      r_dvd   <= 16'd0;
      r_dsr   <= 9'd0;
      r_prem  <= 9'd0;
      r_quo   <= 16'd0;
      r_qneg  <= 1'b0;
      r_rneg  <= 1'b0;
      r_sgn   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_quot  <= 8'h00;
      r_rem   <= 8'h00;
      r_div0  <= 1'b0;
      r_ccr   <= 4'b0000;
    end else begin
      unique case (r_state)
        StIdle: begin
          r_done <= 1'b0;
          if (start_in) begin
            r_busy <= 1'b1;
            r_div0 <= 1'b0;
            r_dvd  <= w_dvd_mag;
            r_dsr  <= w_dsr_mag;
            r_prem <= 9'd0;
            r_quo  <= 16'd0;
            r_qneg <= w_dvd_neg ^ w_dsr_neg;
            r_rneg <= w_dvd_neg;
            r_sgn  <= signed_in;
            if (divisor_in == 8'h00) begin
              r_state <= StDone;
            end else begin
              r_cnt   <= CntLoad;
              r_state <= StCalc;
            end
          end
        end
        StCalc: begin
          r_prem <= w_prem_nxt;
          r_quo  <= w_quo_nxt;
          r_dvd  <= w_dvd_nxt;
          if (r_cnt == 4'd0) begin
            r_state <= StFix;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        StFix: begin
          r_quot  <= w_quot_s;
          r_rem   <= w_rem_s;
          r_ccr   <= pack_ccr(w_quot_s[7], (w_quot_s == 8'h00), w_ovf, w_quot_s[0]);
          r_done  <= 1'b1;
          r_state <= StDone;
        end
        StDone: begin
          // Normal path arrives with done already raised; the divide-by-zero
          // path arrives with it low and raises it here, one edge after start.
          if (r_done) begin
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= StIdle;
          end else begin
            r_done <= 1'b1;
            r_div0 <= 1'b1;
            r_ccr  <= pack_ccr(1'b0, 1'b0, 1'b1, 1'b0);
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign busy_out = r_busy;
  assign done_out = r_done;
  assign quot_out = r_quot;
  assign rem_out  = r_rem;
  assign div0_out = r_div0;
  assign CCRo     = r_ccr;

endmodule
